// File: rtl/vproc_pkg.sv
// Types and helpers shared between the core-side result receiver and the
// coprocessor-side result arbiter.
package vproc_pkg;

  // Number of instruction IDs that can be in flight for a given ID width.
  function automatic int unsigned id_cnt(input int unsigned id_w);
    return 32'd1 << id_w;
  endfunction

  localparam int unsigned XIF_ID_W_MAX = 8;

  typedef struct packed {
    logic [XIF_ID_W_MAX-1:0] id;
    logic [31:0]             data;
    logic [4:0]              rd;
    logic                    we;
    logic                    exc;
    logic [5:0]              exccode;
  } vproc_result_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } vproc_wb_t;

endpackage

// File: rtl/vproc_result_rx_if.sv
// Result channel from the coprocessor to the core: one result per valid/ready
// handshake.
interface vproc_result_rx_if #(
    parameter int unsigned XIF_ID_W = 3
);
    logic                valid;
    logic                ready;
    logic [XIF_ID_W-1:0] id;
    logic [31:0]         data;
    logic [4:0]          rd;
    logic                we;
    logic                exc;
    logic [5:0]          exccode;

    modport master (output valid, id, data, rd, we, exc, exccode, input ready);
    modport slave  (input valid, id, data, rd, we, exc, exccode, output ready);
endinterface

// File: rtl/vproc_skid_reg.sv
// One-entry valid/ready register; it accepts a new item in the same cycle
// the held one drains.
module vproc_skid_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             sync_rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            valid_q <= 1'b0;
        end else if (in_valid_i & in_ready_o) begin
            valid_q <= 1'b1;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (in_valid_i & in_ready_o) begin
            data_q <= in_data_i;
        end
    end
endmodule

// File: rtl/vproc_result_rx.sv
// Core-side receiver for offloaded-instruction results: tracks pending IDs,
// buffers GPR writebacks, captures the first exception and flags protocol errors.
module vproc_result_rx
    import vproc_pkg::*;
#(
    parameter int unsigned XIF_ID_W       = 3,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                issue_valid_i,
    input  logic [XIF_ID_W-1:0] issue_id_i,
    input  logic                issue_we_i,
    vproc_result_rx_if.slave    result_if,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [4:0]          wb_addr_o,
    output logic [31:0]         wb_data_o,
    output logic                exc_valid_o,
    output logic [XIF_ID_W-1:0] exc_id_o,
    output logic [5:0]          exc_code_o,
    input  logic                exc_clear_i,
    input  logic                flush_i,
    output logic [XIF_ID_W:0]   outstanding_o,
    output logic                proto_err_o
);
    localparam int unsigned ID_CNT = id_cnt(XIF_ID_W);

    logic [ID_CNT-1:0]   pending_q, pending_d, expect_we_q;
    logic                rx_ready, hs, res_clean, wb_load, issue_dup, exc_take;
    logic                exc_valid_q, proto_err_q;
    logic [XIF_ID_W-1:0] exc_id_q;
    logic [5:0]          exc_code_q;
    logic                wb_valid;
    vproc_wb_t           wb_in, wb_out;

    assign result_if.ready = rx_ready;
    assign hs        = result_if.valid & rx_ready;
    assign res_clean = pending_q[result_if.id] & (result_if.we == expect_we_q[result_if.id]);
    assign wb_load   = hs & res_clean & result_if.we & ~result_if.exc & (result_if.rd != 5'd0);
    // Re-issuing an ID is legal only when its result retires in the same cycle.
    assign issue_dup = issue_valid_i & pending_q[issue_id_i]
                     & ~(hs & (result_if.id == issue_id_i));
    assign exc_take  = hs & result_if.exc & (~exc_valid_q | exc_clear_i);

    assign wb_in.addr = result_if.rd;
    assign wb_in.data = result_if.data;

    vproc_skid_reg #(.WIDTH($bits(vproc_wb_t))) u_wb_buf (
        .clk_i       (clk_i),
        .sync_rst_i  (sync_rst_i),
        .in_valid_i  (wb_load),
        .in_ready_o  (rx_ready),
        .in_data_i   (wb_in),
        .out_valid_o (wb_valid),
        .out_ready_i (wb_ready_i),
        .out_data_o  (wb_out)
    );

    // Result retires first, then issue sets, then flush wipes everything.
    always_comb begin
        pending_d = pending_q;
        if (hs)            pending_d[result_if.id] = 1'b0;
        if (issue_valid_i) pending_d[issue_id_i]   = 1'b1;
        if (flush_i)       pending_d               = '0;
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            pending_q   <= '0;
            exc_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (exc_take)         exc_valid_q <= 1'b1;
            else if (exc_clear_i) exc_valid_q <= 1'b0;
            if ((hs & ~res_clean) | issue_dup) proto_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue_valid_i) expect_we_q[issue_id_i] <= issue_we_i;
        if (exc_take) begin
            exc_id_q   <= result_if.id;
            exc_code_q <= result_if.exccode;
        end
    end

    always_comb begin
        outstanding_o = '0;
        for (int i = 0; i < ID_CNT; i++) begin
            outstanding_o = outstanding_o + (XIF_ID_W+1)'(pending_q[i]);
        end
    end

    assign wb_valid_o  = wb_valid;
    assign exc_valid_o = exc_valid_q;
    assign proto_err_o = proto_err_q;
    assign wb_addr_o   = wb_valid    ? wb_out.addr : (DONT_CARE_ZERO ? '0 : 'x);
    assign wb_data_o   = wb_valid    ? wb_out.data : (DONT_CARE_ZERO ? '0 : 'x);
    assign exc_id_o    = exc_valid_q ? exc_id_q    : (DONT_CARE_ZERO ? '0 : 'x);
    assign exc_code_o  = exc_valid_q ? exc_code_q  : (DONT_CARE_ZERO ? '0 : 'x);
endmodule

// File: tb/tb_vproc_result_rx.sv
// Directed bench for vproc_result_rx: writeback path, backpressure, exceptions,
// protocol errors, flush and reset behaviour.
module tb_vproc_result_rx;
    logic        clk = 1'b0;
    logic        sync_rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_id = '0;
    logic        issue_we = 1'b0;
    logic        wb_valid, wb_ready = 1'b1;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exc_valid, exc_clear = 1'b0, flush = 1'b0, proto_err;
    logic [2:0]  exc_id;
    logic [5:0]  exc_code;
    logic [3:0]  outstanding;
    int          total = 0;
    int          bad = 0;

    vproc_result_rx_if #(.XIF_ID_W(3)) rif ();

    vproc_result_rx #(.XIF_ID_W(3), .DONT_CARE_ZERO(1'b1)) dut (
        .clk_i(clk), .sync_rst_i(sync_rst),
        .issue_valid_i(issue_valid), .issue_id_i(issue_id), .issue_we_i(issue_we),
        .result_if(rif),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .exc_valid_o(exc_valid), .exc_id_o(exc_id), .exc_code_o(exc_code), .exc_clear_i(exc_clear),
        .flush_i(flush), .outstanding_o(outstanding), .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [2:0] id, input logic we);
        issue_valid = 1'b1; issue_id = id; issue_we = we;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic set_result(input logic [2:0] id, input logic [4:0] rd, input logic [31:0] data,
                              input logic we, input logic exc, input logic [5:0] code);
        rif.valid = 1'b1; rif.id = id; rif.rd = rd; rif.data = data;
        rif.we = we; rif.exc = exc; rif.exccode = code;
    endtask

    task automatic clr_result();
        rif.valid = 1'b0; rif.exc = 1'b0;
    endtask

    task automatic apply_reset();
        sync_rst = 1'b1;
        step();
        step();
        sync_rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (rif.ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", rif.ready); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
        total++; if (exc_valid !== 1'b0) begin bad++; $display("FAIL rst_exc_valid got=%b exp=0", exc_valid); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%b exp=0", proto_err); end
        total++; if (wb_addr !== 5'd0 || exc_id !== 3'd0) begin bad++; $display("FAIL rst_dont_care addr=%0d id=%0d exp=0", wb_addr, exc_id); end
    endtask

    task automatic test_writeback();
        do_issue(3'd2, 1'b1);
        total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL wb_outstanding_1 got=%0d exp=1", outstanding); end
        set_result(3'd2, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 6'd0);
        #1;
        total++; if (rif.ready !== 1'b1) begin bad++; $display("FAIL wb_ready_empty got=%b exp=1", rif.ready); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL wb_latency got=%b exp=0", wb_valid); end
        step(); clr_result();
        total++; if (wb_valid !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin bad++;
            $display("FAIL wb_out got=%b/%0d/%h exp=1/5/deadbeef", wb_valid, wb_addr, wb_data); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL wb_outstanding_0 got=%0d exp=0", outstanding); end
        step();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL wb_drain got=%b exp=0", wb_valid); end
        // rd=0 writeback is dropped without error
        do_issue(3'd1, 1'b1);
        set_result(3'd1, 5'd0, 32'h12345678, 1'b1, 1'b0, 6'd0);
        step(); clr_result();
        total++; if (wb_valid !== 1'b0 || proto_err !== 1'b0 || outstanding !== 4'd0) begin bad++;
            $display("FAIL wb_rd0 got=%b/%b/%0d exp=0/0/0", wb_valid, proto_err, outstanding); end
    endtask

    task automatic test_backpressure();
        do_issue(3'd3, 1'b1);
        do_issue(3'd7, 1'b1);
        wb_ready = 1'b0;
        set_result(3'd7, 5'd9, 32'h11111111, 1'b1, 1'b0, 6'd0);
        step();
        total++; if (wb_valid !== 1'b1 || wb_addr !== 5'd9) begin bad++; $display("FAIL bp_first got=%b/%0d exp=1/9", wb_valid, wb_addr); end
        set_result(3'd3, 5'd10, 32'h22222222, 1'b1, 1'b0, 6'd0);
        #1;
        total++; if (rif.ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", rif.ready); end
        step();
        step();
        total++; if (wb_valid !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'h11111111) begin bad++;
            $display("FAIL bp_hold got=%b/%0d/%h exp=1/9/11111111", wb_valid, wb_addr, wb_data); end
        total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL bp_outstanding got=%0d exp=1", outstanding); end
        wb_ready = 1'b1;
        #1;
        total++; if (rif.ready !== 1'b1) begin bad++; $display("FAIL bp_ready_drain got=%b exp=1", rif.ready); end
        step(); clr_result();
        total++; if (wb_valid !== 1'b1 || wb_addr !== 5'd10 || wb_data !== 32'h22222222) begin bad++;
            $display("FAIL bp_second got=%b/%0d/%h exp=1/10/22222222", wb_valid, wb_addr, wb_data); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL bp_outstanding_0 got=%0d exp=0", outstanding); end
        step();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) do_issue(3'(i), 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_result(3'(i), 5'(i + 1), 32'(100 + i), 1'b1, 1'b0, 6'd0);
            #1;
            total++; if (rif.ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, rif.ready); end
            step();
            total++; if (wb_valid !== 1'b1 || wb_addr !== 5'(i + 1) || wb_data !== 32'(100 + i)) begin bad++;
                $display("FAIL b2b_out[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", i, wb_valid, wb_addr, wb_data, i + 1, 100 + i); end
        end
        clr_result();
        step();
        total++; if (wb_valid !== 1'b0 || outstanding !== 4'd0) begin bad++;
            $display("FAIL b2b_end got=%b/%0d exp=0/0", wb_valid, outstanding); end
    endtask

    task automatic test_exception();
        do_issue(3'd1, 1'b0);
        do_issue(3'd4, 1'b0);
        set_result(3'd1, 5'd3, 32'h0, 1'b0, 1'b1, 6'h0D);
        step(); clr_result();
        total++; if (exc_valid !== 1'b1 || exc_id !== 3'd1 || exc_code !== 6'h0D) begin bad++;
            $display("FAIL exc_first got=%b/%0d/%h exp=1/1/0d", exc_valid, exc_id, exc_code); end
        set_result(3'd4, 5'd3, 32'h0, 1'b0, 1'b1, 6'h0F);
        step(); clr_result();
        total++; if (exc_valid !== 1'b1 || exc_id !== 3'd1 || exc_code !== 6'h0D) begin bad++;
            $display("FAIL exc_retain got=%b/%0d/%h exp=1/1/0d", exc_valid, exc_id, exc_code); end
        total++; if (wb_valid !== 1'b0 || outstanding !== 4'd0 || proto_err !== 1'b0) begin bad++;
            $display("FAIL exc_side got=%b/%0d/%b exp=0/0/0", wb_valid, outstanding, proto_err); end
        exc_clear = 1'b1;
        step(); exc_clear = 1'b0;
        total++; if (exc_valid !== 1'b0) begin bad++; $display("FAIL exc_clear got=%b exp=0", exc_valid); end
        // clear and new exception in the same cycle: the new one is captured
        do_issue(3'd6, 1'b0);
        do_issue(3'd5, 1'b1);
        set_result(3'd6, 5'd0, 32'h0, 1'b0, 1'b1, 6'h02);
        step(); clr_result();
        total++; if (exc_id !== 3'd6 || exc_code !== 6'h02) begin bad++; $display("FAIL exc_second got=%0d/%h exp=6/02", exc_id, exc_code); end
        set_result(3'd5, 5'd7, 32'hAAAA5555, 1'b1, 1'b1, 6'h03);
        exc_clear = 1'b1;
        step(); clr_result(); exc_clear = 1'b0;
        total++; if (exc_valid !== 1'b1 || exc_id !== 3'd5 || exc_code !== 6'h03) begin bad++;
            $display("FAIL exc_clear_capture got=%b/%0d/%h exp=1/5/03", exc_valid, exc_id, exc_code); end
        total++; if (wb_valid !== 1'b0 || proto_err !== 1'b0) begin bad++;
            $display("FAIL exc_no_wb got=%b/%b exp=0/0", wb_valid, proto_err); end
        exc_clear = 1'b1;
        step(); exc_clear = 1'b0;
    endtask

    task automatic test_same_id();
        do_issue(3'd5, 1'b1);
        set_result(3'd5, 5'd3, 32'h5A5A5A5A, 1'b1, 1'b0, 6'd0);
        issue_valid = 1'b1; issue_id = 3'd5; issue_we = 1'b1;
        step(); clr_result(); issue_valid = 1'b0;
        total++; if (outstanding !== 4'd1 || proto_err !== 1'b0) begin bad++;
            $display("FAIL same_id got=%0d/%b exp=1/0", outstanding, proto_err); end
        total++; if (wb_valid !== 1'b1 || wb_addr !== 5'd3) begin bad++; $display("FAIL same_id_wb got=%b/%0d exp=1/3", wb_valid, wb_addr); end
        set_result(3'd5, 5'd0, 32'h0, 1'b1, 1'b0, 6'd0);
        step(); clr_result();
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL same_id_retire got=%0d exp=0", outstanding); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) do_issue(3'(i), 1'b1);
        total++; if (outstanding !== 4'd8) begin bad++; $display("FAIL flush_full got=%0d exp=8", outstanding); end
        flush = 1'b1;
        issue_valid = 1'b1; issue_id = 3'd3; issue_we = 1'b1;
        set_result(3'd2, 5'd4, 32'hCAFE0002, 1'b1, 1'b0, 6'd0);
        step(); flush = 1'b0; issue_valid = 1'b0; clr_result();
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL flush_outstanding got=%0d exp=0", outstanding); end
        total++; if (wb_valid !== 1'b1 || wb_addr !== 5'd4 || wb_data !== 32'hCAFE0002) begin bad++;
            $display("FAIL flush_wb got=%b/%0d/%h exp=1/4/cafe0002", wb_valid, wb_addr, wb_data); end
        step();
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL flush_hold got=%0d exp=0", outstanding); end
    endtask

    task automatic test_proto_err();
        apply_reset();
        set_result(3'd6, 5'd8, 32'h66666666, 1'b1, 1'b0, 6'd0);
        step(); clr_result();
        total++; if (proto_err !== 1'b1 || wb_valid !== 1'b0) begin bad++;
            $display("FAIL proto_unknown got=%b/%b exp=1/0", proto_err, wb_valid); end
        step(); step();
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b exp=1", proto_err); end
        apply_reset();
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_reset got=%b exp=0", proto_err); end
        do_issue(3'd0, 1'b1);
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_single_issue got=%b exp=0", proto_err); end
        do_issue(3'd0, 1'b1);
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_dup_issue got=%b exp=1", proto_err); end
        apply_reset();
        do_issue(3'd1, 1'b0);
        set_result(3'd1, 5'd2, 32'h77777777, 1'b1, 1'b0, 6'd0);
        step(); clr_result();
        total++; if (proto_err !== 1'b1 || wb_valid !== 1'b0 || outstanding !== 4'd0) begin bad++;
            $display("FAIL proto_we got=%b/%b/%0d exp=1/0/0", proto_err, wb_valid, outstanding); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_issue(3'd4, 1'b0);
        do_issue(3'd5, 1'b1);
        set_result(3'd4, 5'd0, 32'h0, 1'b0, 1'b1, 6'h0A);
        step(); clr_result();
        wb_ready = 1'b0;
        set_result(3'd5, 5'd3, 32'h00000055, 1'b1, 1'b0, 6'd0);
        step(); clr_result();
        total++; if (wb_valid !== 1'b1 || exc_valid !== 1'b1) begin bad++;
            $display("FAIL mid_pre got=%b/%b exp=1/1", wb_valid, exc_valid); end
        sync_rst = 1'b1;
        step(); sync_rst = 1'b0;
        total++; if (wb_valid !== 1'b0 || exc_valid !== 1'b0 || outstanding !== 4'd0 || rif.ready !== 1'b1) begin bad++;
            $display("FAIL mid_rst got=%b/%b/%0d/%b exp=0/0/0/1", wb_valid, exc_valid, outstanding, rif.ready); end
        wb_ready = 1'b1;
        step(); step();
        total++; if (wb_valid !== 1'b0 || exc_valid !== 1'b0) begin bad++;
            $display("FAIL mid_no_pulse got=%b/%b exp=0/0", wb_valid, exc_valid); end
    endtask

    initial begin
        rif.valid = 1'b0; rif.id = '0; rif.data = '0; rif.rd = '0;
        rif.we = 1'b0; rif.exc = 1'b0; rif.exccode = '0;
        test_reset();
        test_writeback();
        test_backpressure();
        test_back_to_back();
        test_exception();
        test_same_id();
        test_flush();
        test_proto_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
